// File: rtl/matrix_seq_pkg.sv
// Shared definitions for the matrix sequencer: state encoding, index width, defaults.
package matrix_seq_pkg;
  localparam int IDX_W  = 4;
  localparam int N_DEF  = 3;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_CREAD,
    ST_DONE
  } state_e;
endpackage

// File: rtl/matrix_seq_if.sv
// Stream-in, matrix-register and result signals of the sequencer.
// master = sequencer side, slave = environment / register side.
interface matrix_seq_if #(
  parameter int DW = 8,
  parameter int SW = 10
);
  import matrix_seq_pkg::*;

  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             busy;
  logic             mr_wen;
  logic [DW-1:0]    mr_write_data;
  logic             mr_idx_rst;
  logic [IDX_W-1:0] mr_read_idx;
  logic [DW-1:0]    mr_read_data;
  logic             out_valid;
  logic [SW-1:0]    out_data;
  logic             out_is_col;

  modport master (
    input  in_valid, in_data, mr_read_data,
    output in_ready, busy, mr_wen, mr_write_data, mr_idx_rst, mr_read_idx,
           out_valid, out_data, out_is_col
  );

  modport slave (
    output in_valid, in_data, mr_read_data,
    input  in_ready, busy, mr_wen, mr_write_data, mr_idx_rst, mr_read_idx,
           out_valid, out_data, out_is_col
  );
endinterface

// File: rtl/matrix_row_acc.sv
// Clear-on-first / add / emit accumulator with registered result; one result per
// run of N elements. Shared by the row and column walks.
module matrix_row_acc #(
  parameter int DW = 8,
  parameter int SW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          first,
  input  logic          emit,
  input  logic          is_col,
  input  logic [DW-1:0] din,
  output logic          out_valid,
  output logic [SW-1:0] out_data,
  output logic          out_is_col
);
  logic [SW-1:0] acc_q, acc_d, out_data_q, out_data_d, sum;
  logic          out_valid_q, out_valid_d, is_col_q, is_col_d;

  always_comb begin
    sum         = (first ? '0 : acc_q) + SW'(din);
    acc_d       = step ? sum : acc_q;
    out_valid_d = step && emit;
    out_data_d  = (step && emit) ? sum : out_data_q;
    is_col_d    = (step && emit) ? is_col : is_col_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      is_col_q    <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      is_col_q    <= is_col_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_is_col = is_col_q;
endmodule

// File: rtl/matrix_seq_ctrl.sv
// Loads an NxN byte matrix row-major, then walks it emitting row sums; with
// MATRIX_SEQ_COLSUM_EN defined a second column-major walk emits column sums.
module matrix_seq_ctrl
  import matrix_seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = DW + $clog2(N)
) (
  input logic          clk,
  input logic          rst,
  matrix_seq_if.master bus
);
  localparam int NN = N * N;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0] outer_q, outer_d, inner_q, inner_d;
  logic [IDX_W-1:0] read_idx;
  logic             in_rdy, accept, step, is_col, inner_end, outer_end;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    outer_d    = outer_q;
    inner_d    = inner_q;
    step       = 1'b0;
    is_col     = 1'b0;
    read_idx   = '0;
    in_rdy     = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    accept     = bus.in_valid && in_rdy;
    inner_end  = (inner_q == IDX_W'(N - 1));
    outer_end  = (outer_q == IDX_W'(N - 1));

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          load_cnt_d = load_cnt_q + 1'b1;
          state_d    = (load_cnt_q == IDX_W'(NN - 1)) ? ST_READ : ST_LOAD;
        end
      end
      ST_READ: begin
        step     = 1'b1;
        read_idx = IDX_W'(int'(outer_q) * N + int'(inner_q));
        if (inner_end && outer_end) begin
`ifdef MATRIX_SEQ_COLSUM_EN
          state_d = ST_CREAD;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MATRIX_SEQ_COLSUM_EN
      // Column walk: outer counts columns, inner counts rows (row index fastest).
      ST_CREAD: begin
        step     = 1'b1;
        is_col   = 1'b1;
        read_idx = IDX_W'(int'(inner_q) * N + int'(outer_q));
        if (inner_end && outer_end) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        load_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Both walks wrap to zero on their last element, so a following walk starts clean.
    if (step) begin
      if (inner_end) begin
        inner_d = '0;
        outer_d = outer_end ? '0 : outer_q + 1'b1;
      end else begin
        inner_d = inner_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      outer_q    <= '0;
      inner_q    <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      outer_q    <= outer_d;
      inner_q    <= inner_d;
    end
  end

  matrix_row_acc #(.DW(DW), .SW(SW)) u_acc (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .first      (inner_q == '0),
    .emit       (inner_end),
    .is_col     (is_col),
    .din        (bus.mr_read_data),
    .out_valid  (bus.out_valid),
    .out_data   (bus.out_data),
    .out_is_col (bus.out_is_col)
  );

  assign bus.in_ready      = in_rdy;
  assign bus.busy          = (state_q == ST_READ) || (state_q == ST_CREAD) || (state_q == ST_DONE);
  assign bus.mr_wen        = accept;
  assign bus.mr_write_data = bus.in_data;
  assign bus.mr_idx_rst    = (state_q == ST_DONE);
  assign bus.mr_read_idx   = read_idx;
endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Scoreboard bench for matrix_seq_ctrl: models the matrix register, predicts sums
// and their cycles from the loaded bytes; honours MATRIX_SEQ_COLSUM_EN.
module tb_matrix_seq_ctrl;
  import matrix_seq_pkg::*;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int SW = DW + $clog2(N);
  localparam int NN = N * N;
`ifdef MATRIX_SEQ_COLSUM_EN
  localparam bit COLSUM = 1'b1;
`else
  localparam bit COLSUM = 1'b0;
`endif
  localparam int LAST = COLSUM ? 2 * NN : NN;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_seq_if #(.DW(DW), .SW(SW)) bus ();

  matrix_seq_ctrl #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Matrix register model: auto-incrementing write index, combinational read.
  logic [DW-1:0] mem [16];
  int widx;
  always @(posedge clk) begin
    if (rst) begin
      widx <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (bus.mr_idx_rst) widx <= 0;
      if (bus.mr_wen && widx < 16) begin
        mem[widx] <= bus.mr_write_data;
        widx      <= widx + 1;
      end
    end
  end
  assign bus.mr_read_data = mem[bus.mr_read_idx];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit col;
    int at;
  } exp_t;
  exp_t sb[$];
  exp_t em;

  int n_chk = 0, n_pass = 0;
  int busy_from = -10, busy_to = -10;
  int idx_rst_seen = 0, mats_done = 0;
  bit mon_on = 1'b0;
  bit eb;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: per-cycle control checks plus scoreboard pops on every result.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      eb = (cyc >= busy_from) && (cyc <= busy_to);
      chk("busy", bus.busy, eb);
      chk("in_ready", bus.in_ready, !eb);
      chk("mr_wen", bus.mr_wen, bus.in_valid && !eb);
      if (bus.mr_wen) chk("mr_write_data", bus.mr_write_data, bus.in_data);
      chk("mr_idx_rst", bus.mr_idx_rst, cyc == busy_to);
      if (bus.mr_idx_rst) idx_rst_seen++;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL out_valid: unexpected result %0d at cycle %0d, expected none", bus.out_data, cyc);
        end else begin
          em = sb.pop_front();
          chk("out_data", bus.out_data, em.data);
          chk("out_is_col", bus.out_is_col, em.col);
          chk("out_cycle", cyc, em.at);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
  endtask

  // Drive n_send bytes of v; a full matrix also predicts results and rides out the busy window.
  task automatic send(input logic [DW-1:0] v[16], input int n_send, input bit gaps, input bit garb);
    int t, w, s;
    t = 0;
    for (int i = 0; i < n_send; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          bus.in_valid = 1'b0;
          bus.in_data  = DW'($urandom);
          step();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      @(negedge clk);
      w = 0;
      while (!bus.in_ready) begin
        w++;
        if (w > 200) begin
          n_chk++;
          $display("FAIL accept_timeout: in_ready low for %0d cycles, expected high", w);
          summary();
          $fatal(1);
        end
        step();
        @(negedge clk);
      end
      t = cyc;
      step();
    end
    bus.in_valid = 1'b0;
    if (n_send == NN) begin
      for (int r = 0; r < N; r++) begin
        s = 0;
        for (int c = 0; c < N; c++) s += int'(v[r*N+c]);
        sb.push_back('{s, 1'b0, t + 1 + N * (r + 1)});
      end
      if (COLSUM) begin
        for (int c = 0; c < N; c++) begin
          s = 0;
          for (int r = 0; r < N; r++) s += int'(v[r*N+c]);
          sb.push_back('{s, 1'b1, t + 1 + NN + N * (c + 1)});
        end
      end
      busy_from = t + 1;
      busy_to   = t + 1 + LAST;
      mats_done++;
      while (cyc <= busy_to) begin
        bus.in_valid = garb ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_data  = 8'hAA;
        step();
      end
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    summary();
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] v [16];
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < 16; i++) v[i] = '0;
    step();
    step();
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_is_col", bus.out_is_col, 0);
    chk("rst_mr_read_idx", bus.mr_read_idx, 0);
    chk("rst_mr_idx_rst", bus.mr_idx_rst, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_on = 1'b1;

    // 1..9, then all-255 back-to-back in the IDLE cycle after DONE
    for (int i = 0; i < NN; i++) v[i] = DW'(i + 1);
    send(v, NN, 1'b0, 1'b0);
    for (int i = 0; i < NN; i++) v[i] = 8'hFF;
    send(v, NN, 1'b0, 1'b0);

    // in_valid held with 0xAA through READ/DONE must be ignored
    for (int i = 0; i < NN; i++) v[i] = DW'(i + 1);
    send(v, NN, 1'b0, 1'b1);

    // Reset mid-load discards the partial matrix
    for (int i = 0; i < NN; i++) v[i] = DW'($urandom);
    send(v, 5, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_out_valid", bus.out_valid, 0);
    step();
    for (int i = 0; i < NN; i++) v[i] = DW'(NN - i);
    send(v, NN, 1'b0, 1'b0);

    // Random matrices, random gaps and random ignored traffic while busy
    for (int m = 0; m < 12; m++) begin
      for (int i = 0; i < NN; i++) v[i] = DW'($urandom);
      send(v, NN, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (LAST + 6) step();
    chk("sb_empty", sb.size(), 0);
    chk("idx_rst_count", idx_rst_seen, mats_done);
    summary();
    $finish;
  end
endmodule
